// File: rtl/stage_port_arbiter.sv
// Single memory port shared by pipeline lookups and table updates.
// Lookups win; a starved update is forced through after MAX_WAIT refusals.
module stage_port_arbiter #(
  parameter int DATA     = 72,
  parameter int ADDR     = 10,
  parameter int TAG      = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lk_valid,
  output logic            lk_ready,
  input  logic [ADDR-1:0] lk_addr,
  input  logic [TAG-1:0]  lk_tag,
  output logic            lk_rsp_valid,
  output logic [DATA-1:0] lk_rsp_data,
  output logic [TAG-1:0]  lk_rsp_tag,
  input  logic            up_valid,
  output logic            up_ready,
  input  logic [ADDR-1:0] up_addr,
  input  logic [DATA-1:0] up_din,
  output logic            mem_wr,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_din,
  input  logic [DATA-1:0] mem_dout,
  output logic [15:0]     forced_cnt
);

  localparam logic [7:0] MAXW = 8'(MAX_WAIT);

  typedef enum logic {
    NORMAL = 1'b0,
    FORCE  = 1'b1
  } state_e;

  state_e          state_q;
  logic [7:0]      wait_q;
  logic [15:0]     forced_q;
  logic            rsp_valid_q;
  logic [TAG-1:0]  rsp_tag_q;
  logic [ADDR-1:0] addr_q;

  logic lk_acc;
  logic up_acc;
  logic starve;

  always_comb begin
    lk_ready = (state_q == NORMAL);
    up_ready = (state_q == FORCE) || !lk_valid;
    lk_acc   = lk_valid && lk_ready;
    up_acc   = up_valid && up_ready;
    starve   = up_valid && !up_ready;
  end

  // Grants are mutually exclusive, so the case is one-hot.
  always_comb begin
    mem_addr = addr_q;
    unique case (1'b1)
      lk_acc:  mem_addr = lk_addr;
      up_acc:  mem_addr = up_addr;
      default: mem_addr = addr_q;
    endcase
  end

  // No writes may escape while the block is held in reset.
  assign mem_wr       = up_acc && rst_n;
  assign mem_din      = up_din;
  assign lk_rsp_valid = rsp_valid_q;
  assign lk_rsp_tag   = rsp_tag_q;
  assign lk_rsp_data  = mem_dout;
  assign forced_cnt   = forced_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NORMAL;
      wait_q      <= '0;
      forced_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      addr_q      <= '0;
    end else begin
      rsp_valid_q <= lk_acc;
      addr_q      <= mem_addr;
      if (lk_acc)
        rsp_tag_q <= lk_tag;
      if (up_acc && state_q == FORCE && forced_q != 16'hFFFF)
        forced_q <= forced_q + 16'd1;
      if (!up_valid || up_acc)
        wait_q <= '0;
      else if (starve && wait_q != MAXW)
        wait_q <= wait_q + 8'd1;
      if (state_q == FORCE)
        state_q <= NORMAL;
      else if (starve && (wait_q + 8'd1) == MAXW)
        state_q <= FORCE;
    end
  end

endmodule

// File: tb/tb_stage_port_arbiter.sv
// Scoreboard bench for stage_port_arbiter with a behavioural memory
// and a grant/starvation reference model.
module tb_stage_port_arbiter;

  localparam int DATA     = 72;
  localparam int ADDR     = 4;
  localparam int TAG      = 8;
  localparam int MAX_WAIT = 16;
  localparam int DEPTH    = 2 ** ADDR;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lk_valid;
  logic            lk_ready;
  logic [ADDR-1:0] lk_addr;
  logic [TAG-1:0]  lk_tag;
  logic            lk_rsp_valid;
  logic [DATA-1:0] lk_rsp_data;
  logic [TAG-1:0]  lk_rsp_tag;
  logic            up_valid;
  logic            up_ready;
  logic [ADDR-1:0] up_addr;
  logic [DATA-1:0] up_din;
  logic            mem_wr;
  logic [ADDR-1:0] mem_addr;
  logic [DATA-1:0] mem_din;
  logic [DATA-1:0] mem_dout;
  logic [15:0]     forced_cnt;

  always #5 clk = ~clk;

  stage_port_arbiter #(
    .DATA(DATA), .ADDR(ADDR), .TAG(TAG), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_ready(lk_ready),
    .lk_addr(lk_addr), .lk_tag(lk_tag),
    .lk_rsp_valid(lk_rsp_valid), .lk_rsp_data(lk_rsp_data),
    .lk_rsp_tag(lk_rsp_tag),
    .up_valid(up_valid), .up_ready(up_ready),
    .up_addr(up_addr), .up_din(up_din),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .forced_cnt(forced_cnt)
  );

  logic [DATA-1:0] mem [DEPTH];
  logic [DATA-1:0] rd_q;
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_din;
    rd_q <= mem[mem_addr];
  end
  assign mem_dout = rd_q;

  typedef struct {
    logic [TAG-1:0]  tag;
    logic [DATA-1:0] data;
    int unsigned     cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;

  logic [DATA-1:0] ref_mem [DEPTH];
  bit              m_force;
  int              m_starve;
  int              m_forced;
  logic [ADDR-1:0] m_last;
  bit              g_lacc;
  bit              g_uacc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_force  = 1'b0;
    m_starve = 0;
    m_forced = 0;
    m_last   = '0;
    sb.delete();
  endtask

  // One cycle of stimulus: drive at negedge, check the combinational
  // grant outputs against the model, queue expected responses.
  task automatic step(bit lv, logic [ADDR-1:0] la, logic [TAG-1:0] lt,
                      bit uv, logic [ADDR-1:0] ua, logic [DATA-1:0] ud);
    bit              elr;
    bit              eur;
    logic [ADDR-1:0] ea;
    @(negedge clk);
    chk("forced_cnt", 128'(forced_cnt), 128'(m_forced));
    lk_valid = lv; lk_addr = la; lk_tag = lt;
    up_valid = uv; up_addr = ua; up_din = ud;
    elr    = !m_force;
    eur    = m_force || !lv;
    g_lacc = lv && elr;
    g_uacc = uv && eur;
    ea = g_lacc ? la : (g_uacc ? ua : m_last);
    #1;
    chk("lk_ready", 128'(lk_ready), 128'(elr));
    chk("up_ready", 128'(up_ready), 128'(eur));
    chk("mem_wr", 128'(mem_wr), 128'(g_uacc));
    chk("mem_addr", 128'(mem_addr), 128'(ea));
    if (g_uacc) chk("mem_din", 128'(mem_din), 128'(ud));
    if (g_lacc) sb.push_back('{lt, ref_mem[la], cyc + 1});
    if (g_uacc) begin
      ref_mem[ua] = ud;
      if (m_force && m_forced < 65535) m_forced++;
    end
    m_last = ea;
    if (m_force) begin
      m_force  = 1'b0;
      m_starve = 0;
    end else if (uv && !g_uacc) begin
      m_starve++;
      if (m_starve == MAX_WAIT) m_force = 1'b1;
    end else begin
      m_starve = 0;
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (lk_rsp_valid) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected: got tag %0h, no response due at cycle %0d",
                   lk_rsp_tag, cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_tag", 128'(lk_rsp_tag), 128'(mon_e.tag));
          chk("rsp_data", 128'(lk_rsp_data), 128'(mon_e.data));
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_missing: got no response, expected tag %0h at cycle %0d",
                 sb[0].tag, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int              refused;
    bit              uv;
    bit              dense;
    logic [ADDR-1:0] ua;
    logic [DATA-1:0] ud;

    lk_valid = 1'b0; lk_addr = '0; lk_tag = '0;
    up_valid = 1'b0; up_addr = '0; up_din = '0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    chk("reset_rsp_valid", 128'(lk_rsp_valid), 128'(0));
    chk("reset_forced", 128'(forced_cnt), 128'(0));
    chk("reset_mem_addr", 128'(mem_addr), 128'(0));
    chk("reset_lk_ready", 128'(lk_ready), 128'(1));
    chk("reset_up_ready_idle", 128'(up_ready), 128'(1));
    lk_valid = 1'b1;
    #1 chk("reset_up_ready_lk", 128'(up_ready), 128'(0));
    lk_valid = 1'b0;
    up_valid = 1'b1;
    #1 chk("reset_mem_wr", 128'(mem_wr), 128'(0));
    up_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      step(1'b0, '0, '0, 1'b1, ADDR'(i), DATA'({$urandom(), $urandom(), $urandom()}));

    step(1'b1, 4'd0, 8'd5, 1'b0, '0, '0);
    step(1'b1, 4'd1, 8'd6, 1'b0, '0, '0);
    step(1'b1, 4'd2, 8'd7, 1'b0, '0, '0);
    idle(2);

    step(1'b0, '0, '0, 1'b1, 4'd3, 72'hAB);
    chk("idle_update_wr", 128'(mem_wr), 128'(1));
    step(1'b1, 4'd3, 8'd9, 1'b0, '0, '0);
    idle(2);

    refused = 0;
    for (int k = 0; k < 40; k++) begin
      step(1'b1, ADDR'($urandom()), TAG'($urandom()), 1'b1, 4'd5, 72'h5A5A_0000_1234);
      if (g_uacc) break;
      refused++;
    end
    chk("starve_refused", 128'(refused), 128'(MAX_WAIT));
    chk("force_lk_ready", 128'(lk_ready), 128'(0));
    step(1'b1, 4'd5, 8'h55, 1'b0, '0, '0);
    chk("lk_resume", 128'(lk_ready), 128'(1));
    chk("forced_one", 128'(forced_cnt), 128'(1));
    idle(2);

    for (int k = 0; k < MAX_WAIT; k++)
      step(1'b1, ADDR'($urandom()), TAG'($urandom()), 1'b1, 4'd6, 72'h66);
    step(1'b1, 4'd6, 8'h66, 1'b0, 4'd6, 72'h66);
    chk("withdraw_mem_wr", 128'(mem_wr), 128'(0));
    chk("withdraw_lk_ready", 128'(lk_ready), 128'(0));
    step(1'b1, 4'd6, 8'h67, 1'b0, '0, '0);
    chk("withdraw_normal", 128'(lk_ready), 128'(1));
    chk("withdraw_forced", 128'(forced_cnt), 128'(1));
    idle(2);

    step(1'b1, 4'd2, 8'h33, 1'b0, '0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    lk_valid = 1'b0;
    up_valid = 1'b0;
    model_reset();
    #1;
    chk("midrst_rsp_valid", 128'(lk_rsp_valid), 128'(0));
    chk("midrst_forced", 128'(forced_cnt), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3);

    uv = 1'b0; ua = '0; ud = '0; dense = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) dense = ($urandom_range(0, 1) == 1);
      if (!uv || g_uacc || $urandom_range(0, 9) == 0) begin
        uv = ($urandom_range(0, 3) == 0);
        ua = ADDR'($urandom());
        ud = DATA'({$urandom(), $urandom(), $urandom()});
      end
      step(dense ? ($urandom_range(0, 99) < 97) : ($urandom_range(0, 1) == 1),
           ADDR'($urandom()), TAG'($urandom()), uv, ua, ud);
    end
    idle(4);
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
